operand_loader: RTL and testbench
=================================

// Module: operand_loader
// PURPOSE
//  Upstream feeder for the int8 outer-product stage of the ECG classifier datapath.
//  Collects a byte stream into vector A (NA elements), then vector B (NB elements).
//  Presents both as stable parallel operand arrays, pulses start, and holds them
//  until the consumer reports done.
//  Double-buffered: the next frame fills while the consumer computes on the current one.
// PARAMETERS
//  NA  15  elements in vector A (first NA bytes of a frame)
//  NB  16  elements in vector B (next NB bytes of a frame)
//  DW  8   element width, signed two's complement
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  rst        in   1        asynchronous, active-low reset (asserted when 0)
//  in_valid   in   1        upstream byte valid
//  in_ready   out  1        loader can accept a byte
//  in_data    in   DW       signed element, A[0..NA-1] then B[0..NB-1]
//  in_last    in   1        marks final byte of a frame
//  mat_a      out  DW x NA  operand A array [0:NA-1], stable while busy
//  mat_b      out  DW x NB  operand B array [0:NB-1], stable while busy
//  start      out  1        1-cycle pulse: new operands valid on mat_a/mat_b
//  busy       out  1        consumer owns current operands
//  done_in    in   1        consumer finished (1-cycle pulse)
//  frame_err  out  1        1-cycle pulse: framing error, frame discarded
// BEHAVIOUR
//  Reset (rst=0, async):
//   - mat_a/mat_b = 0; start, busy, frame_err = 0.
//   - Fill buffer and index cleared, state = FILL.
//   - in_ready = 0 while reset is held, 1 from the first cycle after release.
//   - A reset mid-frame or mid-compute discards all data.
//  Handshake: byte transfers when in_valid & in_ready. in_ready = (state==FILL), combinational.
//  Index idx counts 0..NA+NB-1; transfer k goes to A[k] (k<NA), else B[k-NA].
//  FSM:
//   - FILL: accept bytes.
//     - Transfer at idx=NA+NB-1 with in_last=1: go to FULL, idx=0.
//     - in_last=1 with idx<NA+NB-1, or idx=NA+NB-1 with in_last=0:
//       frame_err=1 next cycle, idx=0, stay FILL, fill buffer contents don't-care.
//   - FULL: in_ready=0.
//     - When busy_eff = busy & ~done_in is 0: copy fill buffer to mat_a/mat_b at this
//       edge, start=1 and busy=1 next cycle, go to FILL.
//     - Otherwise stay in FULL.
//  Latency:
//   - Final byte handshake at cycle T; with consumer idle, start is high in cycle T+2.
//   - With consumer busy, start is high the cycle after done_in.
//   - in_ready returns high in the same cycle start is high.
//  busy: set with start, cleared the cycle after done_in.
//   - done_in while busy=0 is ignored.
//   - done_in in the same cycle as a FULL transfer: clear and set coincide, busy stays 1.
//  mat_a/mat_b change only on a FULL transfer; never while busy and no done_in.
//  Arithmetic: none; data stored bit-exact, sign preserved.
//  idx is 5 bits for defaults, $clog2(NA+NB) generally; never wraps past NA+NB-1.
//  in_data/in_last are ignored when in_ready=0 (no transfer).
// TESTING
//  T1 basic:
//   - Stimulus: frame A=1..15, B=-1..-16, in_last on byte 31, consumer idle.
//   - Response: start in T+2; mat_a[0]=1, mat_a[14]=15, mat_b[0]=-1, mat_b[15]=-16;
//     busy=1; frame_err never.
//  T2 double buffer:
//   - Stimulus: frame2 (A=B=0x55) sent right after T1 start, done_in 20 cycles later.
//   - Response: in_ready=0 after byte 31; mat_* keep frame1 values until done_in;
//     start the cycle after done_in; mat_a[*]=0x55.
//  T3 early last:
//   - Stimulus: in_last on byte 10.
//   - Response: frame_err pulse next cycle; no start; next full frame (A=2, B=3) loads
//     correctly.
//  T4 missing last:
//   - Stimulus: 31 bytes with in_last=0.
//   - Response: frame_err pulse; no start; mat_* unchanged.
//  T5 gaps:
//   - Stimulus: T1 frame with in_valid randomly low 50% of cycles.
//   - Response: same mat_* values as T1; one start.
//  T6 reset mid-frame:
//   - Stimulus: rst=0 after 20 bytes, with busy=1.
//   - Response: mat_*=0, busy=0, start=0 immediately; in_ready=1 after release;
//     a fresh frame loads per T1.
//  Also: done_in with busy=0 causes no state change.

Source files
------------

// File: rtl/operand_loader.sv
// Byte-stream operand loader: fills vector A then B into a shadow buffer, then
// hands the whole frame to the outer-product consumer while the next frame fills.
module operand_loader #(
    parameter int NA = 15,
    parameter int NB = 16,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_last,
    output logic signed [DW-1:0] mat_a [0:NA-1],
    output logic signed [DW-1:0] mat_b [0:NB-1],
    output logic                 start,
    output logic                 busy,
    input  logic                 done_in,
    output logic                 frame_err,
    output logic                 state_dbg
);

    localparam int N  = NA + NB;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        idx_q;
    logic signed [DW-1:0] buf_a_q [0:NA-1];
    logic signed [DW-1:0] buf_b_q [0:NB-1];
    logic signed [DW-1:0] mat_a_q [0:NA-1];
    logic signed [DW-1:0] mat_b_q [0:NB-1];
    logic                 start_q;
    logic                 busy_q;
    logic                 frame_err_q;

    logic xfer;
    logic busy_eff;
    logic load;

    // Handshake: a byte moves on a rising edge where in_valid and in_ready are
    // both high; in_ready depends only on state (and is held low in reset).
    assign in_ready  = rst & (state_q == FILL);
    assign xfer      = in_valid & in_ready;
    assign busy_eff  = busy_q & ~done_in;
    assign load      = (state_q == FULL) & ~busy_eff;

    assign mat_a     = mat_a_q;
    assign mat_b     = mat_b_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NA; i++) begin
                buf_a_q[i] <= '0;
                mat_a_q[i] <= '0;
            end
            for (int j = 0; j < NB; j++) begin
                buf_b_q[j] <= '0;
                mat_b_q[j] <= '0;
            end
        end else begin
            start_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (xfer) begin
                        for (int i = 0; i < NA; i++) begin
                            if (idx_q == IW'(i)) buf_a_q[i] <= in_data;
                        end
                        for (int j = 0; j < NB; j++) begin
                            if (idx_q == IW'(NA + j)) buf_b_q[j] <= in_data;
                        end
                        // A frame must end exactly on its last element with in_last set.
                        if ((idx_q == LAST_IDX) && in_last) begin
                            state_q <= FULL;
                            idx_q   <= '0;
                        end else if ((idx_q == LAST_IDX) || in_last) begin
                            frame_err_q <= 1'b1;
                            idx_q       <= '0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                FULL: begin
                    if (load) begin
                        mat_a_q <= buf_a_q;
                        mat_b_q <= buf_b_q;
                        start_q <= 1'b1;
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
            // A hand-over in the same cycle as done_in keeps busy asserted.
            if (load) begin
                busy_q <= 1'b1;
            end else if (done_in) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: a frame-level model pushes expected
// hand-overs and framing errors; a negedge monitor pops and compares them.
module tb_operand_loader;

    localparam int NA = 15;
    localparam int NB = 16;
    localparam int DW = 8;
    localparam int N  = NA + NB;
    localparam int W  = 1 + N * DW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DW-1:0]        in_data = '0;
    logic                 in_last = 1'b0;
    logic signed [DW-1:0] mat_a [0:NA-1];
    logic signed [DW-1:0] mat_b [0:NB-1];
    logic                 start;
    logic                 busy;
    logic                 done_in = 1'b0;
    logic                 frame_err;
    logic                 state_dbg;

    operand_loader #(.NA(NA), .NB(NB), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mat_a     (mat_a),
        .mat_b     (mat_b),
        .start     (start),
        .busy      (busy),
        .done_in   (done_in),
        .frame_err (frame_err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0]    exp_q[$];
    logic [DW-1:0]   acc [N];
    int              acc_n = 0;
    logic [DW-1:0]   fr [N];
    logic [N*DW-1:0] cur_mat = '0;
    logic [W-1:0]    mon_e;
    int              start_cnt = 0;
    int              hs_cyc = 0;

    task automatic report();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*DW-1:0] mat_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < NA; i++) v[i*DW +: DW] = mat_a[i];
        for (int j = 0; j < NB; j++) v[(NA+j)*DW +: DW] = mat_b[j];
        return v;
    endfunction

    // Frame-level reference: a frame closes at in_last or after N bytes;
    // it is good only when both happen together, otherwise it is an error.
    task automatic model_byte(input logic [DW-1:0] d, input logic l);
        logic [W-1:0] v;
        acc[acc_n] = d;
        acc_n++;
        if (l || acc_n == N) begin
            v = '0;
            if (l && acc_n == N) begin
                for (int k = 0; k < N; k++) v[k*DW +: DW] = acc[k];
            end else begin
                v[W-1] = 1'b1;
            end
            exp_q.push_back(v);
            acc_n = 0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            cur_mat = '0;
        end else begin
            if (start) begin
                start_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL start_unexpected: got start with empty queue (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e[W-1] || mat_vec() !== mon_e[N*DW-1:0]) begin
                        n_err++;
                        $display("FAIL frame_data: got err=0 mat=%h expected err=%0b mat=%h", mat_vec(), mon_e[W-1], mon_e[N*DW-1:0]);
                    end
                    cur_mat = mon_e[N*DW-1:0];
                end
            end else begin
                n_cmp++;
                if (mat_vec() !== cur_mat) begin
                    n_err++;
                    $display("FAIL mat_stable: got %h expected %h (cycle %0d)", mat_vec(), cur_mat, cyc);
                end
            end
            if (frame_err) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL frame_err_unexpected: got frame_err with empty queue (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e[W-1]) begin
                        n_err++;
                        $display("FAIL frame_err_kind: got frame_err expected good frame (cycle %0d)", cyc);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_byte(input logic [DW-1:0] d, input logic l, input int gap);
        int w;
        w = 0;
        while (gap > 0 && $urandom_range(99) < gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready) begin
            @(negedge clk);
            w++;
            if (w > 500) begin
                n_cmp++;
                n_err++;
                $display("FAIL ready_timeout: got in_ready=0 for %0d cycles expected 1", w);
                report();
                $finish;
            end
        end
        @(posedge clk);
        hs_cyc = cyc;
        model_byte(d, l);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_seq(input int cnt, input int last_at, input int gap);
        for (int k = 0; k < cnt; k++) send_byte(fr[k], (k == last_at), gap);
    endtask

    task automatic pulse_done();
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
    endtask

    task automatic wait_start(input int max_cyc);
        int w;
        w = 0;
        while (!start) begin
            @(negedge clk);
            w++;
            if (w > max_cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL start_timeout: got no start in %0d cycles expected one", max_cyc);
                break;
            end
        end
    endtask

    task automatic release_consumer();
        repeat ($urandom_range(0, 4)) @(negedge clk);
        if (busy) begin
            pulse_done();
            @(negedge clk);
        end
    endtask

    task automatic t1_frame();
        for (int k = 0; k < N; k++) fr[k] = (k < NA) ? DW'(k + 1) : DW'(-(k - NA + 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sc0;
        int dc;
        int kind;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_mat_zero", (mat_vec() == '0), 1);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        @(negedge clk);

        // T1 basic
        t1_frame();
        send_seq(N, N - 1, 0);
        chk("t1_no_start_t1", start, 0);
        chk("t1_full_ready", in_ready, 0);
        @(negedge clk);
        chk("t1_start", start, 1);
        chk("t1_latency", cyc, hs_cyc + 2);
        chk("t1_busy", busy, 1);
        chk("t1_ready_back", in_ready, 1);
        chk("t1_a0", mat_a[0], 1);
        chk("t1_a14", mat_a[14], 15);
        chk("t1_b0", mat_b[0], -1);
        chk("t1_b15", mat_b[15], -16);

        // T2 double buffer
        for (int k = 0; k < N; k++) fr[k] = 8'h55;
        send_seq(N, N - 1, 0);
        chk("t2_ready_low", in_ready, 0);
        chk("t2_busy", busy, 1);
        repeat (20) @(negedge clk);
        chk("t2_hold_a0", mat_a[0], 1);
        chk("t2_no_start", start, 0);
        dc = cyc;
        pulse_done();
        chk("t2_start", start, 1);
        chk("t2_latency", cyc, dc + 1);
        chk("t2_busy_kept", busy, 1);
        chk("t2_a0", mat_a[0], 8'h55);
        chk("t2_b15", mat_b[15], 8'h55);
        pulse_done();
        chk("t2_busy_clear", busy, 0);

        // done_in while idle changes nothing
        pulse_done();
        chk("idle_done_busy", busy, 0);
        chk("idle_done_start", start, 0);
        chk("idle_done_ready", in_ready, 1);

        // T3 early last
        for (int k = 0; k < N; k++) fr[k] = DW'($urandom);
        send_seq(11, 10, 0);
        chk("t3_err", frame_err, 1);
        chk("t3_no_start", start, 0);
        @(negedge clk);
        chk("t3_err_pulse", frame_err, 0);
        for (int k = 0; k < N; k++) fr[k] = (k < NA) ? 8'd2 : 8'd3;
        send_seq(N, N - 1, 0);
        wait_start(10);
        chk("t3_a7", mat_a[7], 2);
        chk("t3_b3", mat_b[3], 3);
        @(negedge clk);
        release_consumer();

        // T4 missing last
        for (int k = 0; k < N; k++) fr[k] = DW'($urandom);
        send_seq(N, -1, 0);
        chk("t4_err", frame_err, 1);
        chk("t4_no_start", start, 0);
        chk("t4_state_fill", state_dbg, 0);
        chk("t4_a7_kept", mat_a[7], 2);
        @(negedge clk);

        // T5 gaps
        t1_frame();
        sc0 = start_cnt;
        send_seq(N, N - 1, 50);
        wait_start(10);
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("t5_one_start", start_cnt, sc0 + 1);
        chk("t5_a14", mat_a[14], 15);
        chk("t5_b15", mat_b[15], -16);

        // T6 reset mid-frame while busy
        chk("t6_busy_before", busy, 1);
        for (int k = 0; k < N; k++) fr[k] = DW'($urandom);
        send_seq(20, -1, 0);
        rst = 1'b0;
        exp_q.delete();
        acc_n = 0;
        #1;
        chk("t6_mat_zero", (mat_vec() == '0), 1);
        chk("t6_busy", busy, 0);
        chk("t6_start", start, 0);
        chk("t6_ready_rst", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_ready_rel", in_ready, 1);
        @(negedge clk);
        t1_frame();
        send_seq(N, N - 1, 0);
        @(negedge clk);
        chk("t6_start_after", start, 1);
        chk("t6_latency", cyc, hs_cyc + 2);
        chk("t6_b0", mat_b[0], -1);
        @(negedge clk);

        // Randomised frames, some with misplaced in_last
        for (int r = 0; r < 12; r++) begin
            release_consumer();
            for (int k = 0; k < N; k++) fr[k] = DW'($urandom);
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                send_seq($urandom_range(1, N - 1), -2, 0);
                send_byte(DW'($urandom), 1'b1, 0);
                chk("rnd_early_err", frame_err, 1);
            end else begin
                send_seq(N, N - 1, $urandom_range(0, 60));
                wait_start(10);
            end
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        report();
        $finish;
    end

    initial begin
        #2_000_000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        report();
        $finish;
    end

endmodule
